// File: rtl/sorted_stream_stats_pkg.sv
// ============================================================================
//  Module  : sorted_stats_pkg
//  Brief   : Shared types and width helpers for the sorted-frame statistics
//            block (FSM state encoding, counter width, median index).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sorted_stats_pkg;

  // Default frame length used when the top is instantiated without override
  localparam int DEF_ARRAY_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    EMIT    = 2'd3
  } state_t;

  // Bits needed to count 0..n inclusive
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Lower median position within an n-word frame
  function automatic int median_index(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sorted_stream_stats_accum.sv
// ============================================================================
//  Module  : stats_accum
//  Brief   : Running sum, unique-value count and previous-word register for
//            one frame. 'load' starts a frame with word 0, 'accum' folds in
//            each following word.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stats_accum #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    accum,
  input  logic [DATA_W-1:0]       data,
  output logic [DATA_W+CNT_W-1:0] sum,
  output logic [CNT_W-1:0]        uniq,
  output logic [DATA_W-1:0]       prev
);

  // Sum is widened before the add so a full frame of max words cannot wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      uniq <= '0;
      prev <= '0;
    end else if (load) begin
      sum  <= {{CNT_W{1'b0}}, data};
      uniq <= CNT_W'(1);
      prev <= data;
    end else if (accum) begin
      sum  <= sum + {{CNT_W{1'b0}}, data};
      if (data != prev) begin
        uniq <= uniq + 1'b1;
      end
      prev <= data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sorted_stream_stats.sv
// ============================================================================
//  Module  : sorted_stream_stats
//  Brief   : Reduces one sorted frame (ARRAY_SIZE words, one per cycle) to
//            min, max, lower median, sum and unique count, held on a
//            valid/ready output. Frames arriving while a result is pending
//            are dropped and flagged with 'overrun'.
//  Config  : SORT_CHECK_EN - when defined, a word smaller than its
//            predecessor marks the frame bad; the frame ends with an
//            'order_err' pulse instead of a result.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sorted_stream_stats
  import sorted_stats_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = cnt_width(ARRAY_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_min,
  output logic [DATA_W-1:0]       out_max,
  output logic [DATA_W-1:0]       out_median,
  output logic [DATA_W+CNT_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_uniq,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    order_err
);

  localparam int              MED_IDX  = median_index(ARRAY_SIZE);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ARRAY_SIZE);
  localparam logic [CNT_W-1:0] MED_CNT  = CNT_W'(MED_IDX);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ARRAY_SIZE - 1);

  state_t                    state;
  logic                      in_valid_q;
  logic [CNT_W-1:0]          cnt;
  logic [DATA_W-1:0]         min_r;
  logic [DATA_W-1:0]         max_r;
  logic [DATA_W-1:0]         med_r;
  logic                      order_bad;

  logic                      run_start;
  logic                      acc_load;
  logic                      acc_step;
  logic                      word_low;
  logic [DATA_W+CNT_W-1:0]   acc_sum;
  logic [CNT_W-1:0]          acc_uniq;
  logic [DATA_W-1:0]         acc_prev;

  // A run starts only on a rising in_valid, so a run already in progress
  // (e.g. one that began while a result was pending) is never picked up
  assign run_start = in_valid & ~in_valid_q;
  assign acc_load  = (state == IDLE) && run_start;
  assign acc_step  = (state == CAPTURE) && in_valid && (cnt != FULL_CNT);

  stats_accum #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_accum (
    .clk   (clk),
    .rst   (rst),
    .load  (acc_load),
    .accum (acc_step),
    .data  (in_data),
    .sum   (acc_sum),
    .uniq  (acc_uniq),
    .prev  (acc_prev)
  );

`ifdef SORT_CHECK_EN
  assign word_low = (in_data < acc_prev);
`else
  logic unused_prev;
  assign word_low    = 1'b0;
  assign unused_prev = ^acc_prev;
`endif

  // Frame FSM: capture tracking, result registers and one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_valid_q <= 1'b0;
      cnt        <= '0;
      min_r      <= '0;
      max_r      <= '0;
      med_r      <= '0;
      order_bad  <= 1'b0;
      out_valid  <= 1'b0;
      out_min    <= '0;
      out_max    <= '0;
      out_median <= '0;
      out_sum    <= '0;
      out_uniq   <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      order_err  <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      order_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (run_start) begin
            min_r     <= in_data;
            cnt       <= CNT_W'(1);
            order_bad <= 1'b0;
            if (MED_IDX == 0) begin
              med_r <= in_data;
            end
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (in_valid) begin
            if (cnt == FULL_CNT) begin
              frame_err <= 1'b1;
              state     <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == MED_CNT) begin
                med_r <= in_data;
              end
              if (cnt == LAST_CNT) begin
                max_r <= in_data;
              end
              if (word_low) begin
                order_bad <= 1'b1;
              end
            end
          end else if (cnt != FULL_CNT) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (order_bad) begin
            order_err <= 1'b1;
            state     <= IDLE;
          end else begin
            out_min    <= min_r;
            out_max    <= max_r;
            out_median <= med_r;
            out_sum    <= acc_sum;
            out_uniq   <= acc_uniq;
            out_valid  <= 1'b1;
            state      <= EMIT;
          end
        end

        DRAIN: begin
          if (!in_valid) begin
            state <= IDLE;
          end
        end

        EMIT: begin
          if (run_start) begin
            overrun <= 1'b1;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? DRAIN : IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
